// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port, execute redirect and decode handshake.
// master = fetch unit view, slave = memory/execute/decode view.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    modport master (
        output imem_addr, id_valid, id_pc, id_instr,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_pc, id_instr,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// PC / fetch-control stage in front of a one-cycle-latency instruction memory, with skid
// buffer, redirect and sticky fault. Define FETCH_PERF_CNT_EN to build the perf counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fetch_en,
    fetch_unit_if.master bus,
    output logic         fault,
    output logic [31:0]  fault_pc,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stalls
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_ADDR);
    endfunction

    state_t      state_r, state_s;
    logic [31:0] pc_r, inflight_pc_r, skid_pc_r, skid_instr_r;
    logic        inflight_valid_r, skid_valid_r;
    logic        active_s, redirect_s, want_issue_s, issue_s, fault_hit_s, id_valid_s;
    logic [31:0] target_s;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fault_hit_s) begin
                    state_s = ST_FAULT;
                end else if (fetch_en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fault_hit_s) begin
                    state_s = ST_FAULT;
                end else if (!fetch_en && !inflight_valid_r && !skid_valid_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FAULT: state_s = ST_FAULT;
            default:  state_s = ST_FAULT;
        endcase
    end

    // FSM outputs: issue decision, memory address and the decode-side output mux.
    always_comb begin
        active_s   = (state_r != ST_FAULT);
        redirect_s = active_s & bus.redirect_valid;
        if (redirect_s) begin
            want_issue_s = fetch_en;
        end else if (state_r == ST_RUN) begin
            want_issue_s = fetch_en & (bus.id_ready | (!inflight_valid_r & !skid_valid_r));
        end else begin
            want_issue_s = 1'b0;
        end
        target_s      = redirect_s ? bus.redirect_pc : pc_r;
        fault_hit_s   = want_issue_s & addr_bad(target_s);
        issue_s       = want_issue_s & !fault_hit_s;
        bus.imem_addr = (redirect_s & fetch_en) ? bus.redirect_pc : pc_r;

        // Redirect cycles present a bubble: the held instruction is on the wrong path.
        id_valid_s   = active_s & !redirect_s & (skid_valid_r | inflight_valid_r);
        bus.id_valid = id_valid_s;
        if (!id_valid_s) begin
            bus.id_pc    = 32'h0000_0000;
            bus.id_instr = 32'h0000_0000;
        end else if (skid_valid_r) begin
            bus.id_pc    = skid_pc_r;
            bus.id_instr = skid_instr_r;
        end else begin
            bus.id_pc    = inflight_pc_r;
            bus.id_instr = bus.imem_rdata;
        end
    end

    // PC, in-flight tracking, skid entry and sticky fault capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r             <= RESET_PC;
            inflight_valid_r <= 1'b0;
            inflight_pc_r    <= 32'h0000_0000;
            skid_valid_r     <= 1'b0;
            skid_pc_r        <= 32'h0000_0000;
            skid_instr_r     <= 32'h0000_0000;
            fault            <= 1'b0;
            fault_pc         <= 32'h0000_0000;
        end else if (state_r != ST_FAULT) begin
            if (fault_hit_s) begin
                inflight_valid_r <= 1'b0;
                skid_valid_r     <= 1'b0;
                fault            <= 1'b1;
                fault_pc         <= target_s;
            end else if (redirect_s) begin
                skid_valid_r     <= 1'b0;
                inflight_valid_r <= issue_s;
                inflight_pc_r    <= bus.redirect_pc;
                pc_r             <= issue_s ? (bus.redirect_pc + 32'd4) : bus.redirect_pc;
            end else begin
                if (issue_s) begin
                    pc_r             <= pc_r + 32'd4;
                    inflight_valid_r <= 1'b1;
                    inflight_pc_r    <= pc_r;
                end else begin
                    inflight_valid_r <= 1'b0;
                end
                // Memory data lives only one cycle, so a refused response is parked here.
                if (inflight_valid_r && !bus.id_ready) begin
                    skid_valid_r <= 1'b1;
                    skid_pc_r    <= inflight_pc_r;
                    skid_instr_r <= bus.imem_rdata;
                end else if (skid_valid_r && bus.id_ready) begin
                    skid_valid_r <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Handshake and back-pressure event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_stalls  <= 32'd0;
        end else begin
            if (id_valid_s && bus.id_ready) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (id_valid_s && !bus.id_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`else
    assign perf_fetched = 32'd0;
    assign perf_stalls  = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit; memory word k holds 0x1000+k.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        fault;
    logic [31:0] fault_pc, perf_fetched, perf_stalls;
    int          checks = 0;
    int          failures = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(1024)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_en(fetch_en),
        .bus(bus),
        .fault(fault),
        .fault_pc(fault_pc),
        .perf_fetched(perf_fetched),
        .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory with one-cycle read latency.
    always @(posedge clk) bus.imem_rdata <= 32'h0000_1000 + (bus.imem_addr >> 2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, bus.id_valid}, {31'd0, v});
        chk({tag, "_pc"}, bus.id_pc, pc);
        chk({tag, "_instr"}, bus.id_instr, v ? (32'h0000_1000 + (pc >> 2)) : 32'h0);
    endtask

    task automatic start_after_reset();
        rst = 1'b1; fetch_en = 1'b0; bus.id_ready = 1'b0; bus.redirect_valid = 1'b0;
        go();
        rst = 1'b0; fetch_en = 1'b1; bus.id_ready = 1'b1;
        #1;
    endtask

    logic [31:0] exp_pc, last_pc;
    logic        prev_stall;
    int          hs;

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        #2;
        chk_out("rst", 1'b0, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_perf_f", perf_fetched, 32'd0);

        // Sequential fetch, stall on pc 8, redirect while stalled on 0x10.
        go();
        rst = 1'b0; fetch_en = 1'b1; bus.id_ready = 1'b1; #1;
        chk_out("c0", 1'b0, 32'h0); chk("c0_addr", bus.imem_addr, 32'h0);
        go(); #1;
        chk_out("c1", 1'b0, 32'h0); chk("c1_addr", bus.imem_addr, 32'h0);
        go(); #1;
        chk_out("c2", 1'b1, 32'h0); chk("c2_addr", bus.imem_addr, 32'h4);
        go(); #1;
        chk_out("c3", 1'b1, 32'h4);
        go(); bus.id_ready = 1'b0; #1;
        chk_out("c4", 1'b1, 32'h8); chk("c4_addr", bus.imem_addr, 32'hC);
        go(); #1; chk_out("c5", 1'b1, 32'h8);
        go(); #1; chk_out("c6", 1'b1, 32'h8);
        go(); bus.id_ready = 1'b1; #1; chk_out("c7", 1'b1, 32'h8);
        go(); #1; chk_out("c8", 1'b1, 32'hC);
        chk("c8_perf_stalls", perf_stalls, PERF ? 32'd3 : 32'd0);
        chk("c8_perf_fetched", perf_fetched, PERF ? 32'd3 : 32'd0);
        go(); bus.id_ready = 1'b0; #1; chk_out("c9", 1'b1, 32'h10);
        go(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; #1;
        chk_out("c10", 1'b0, 32'h0); chk("c10_addr", bus.imem_addr, 32'h40);
        go(); bus.redirect_valid = 1'b0; bus.id_ready = 1'b1; #1; chk_out("c11", 1'b1, 32'h40);
        go(); #1; chk_out("c12", 1'b1, 32'h44);

        // Misaligned redirect faults; later redirects are ignored.
        go(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h42; #1;
        chk_out("c13", 1'b0, 32'h0); chk("c13_fault", {31'd0, fault}, 32'd0);
        go(); bus.redirect_valid = 1'b0; #1;
        chk("c14_fault", {31'd0, fault}, 32'd1); chk("c14_fault_pc", fault_pc, 32'h42);
        chk_out("c14", 1'b0, 32'h0); chk("c14_addr", bus.imem_addr, 32'h4C);
        go(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0; #1;
        chk_out("c15", 1'b0, 32'h0); chk("c15_addr", bus.imem_addr, 32'h4C);
        go(); bus.redirect_valid = 1'b0; #1;
        chk_out("c16", 1'b0, 32'h0); chk("c16_fault_pc", fault_pc, 32'h42);
        chk("c16_fault", {31'd0, fault}, 32'd1); chk("c16_addr", bus.imem_addr, 32'h4C);

        // Sequential run to the top of memory, then range fault.
        start_after_reset();
        chk("top_rst_fault", {31'd0, fault}, 32'd0);
        go(); #1;
        for (int k = 0; k < 256; k++) begin
            go(); #1;
            chk_out("top_seq", 1'b1, 32'(k * 4));
            chk("top_seq_fault", {31'd0, fault}, 32'd0);
        end
        go(); #1;
        chk("top_fault", {31'd0, fault}, 32'd1);
        chk("top_fault_pc", fault_pc, 32'h400);
        chk_out("top_after", 1'b0, 32'h0);

        // Reset asserted while the skid entry is full.
        start_after_reset();
        go(); #1;
        go(); bus.id_ready = 1'b0; #1; chk_out("sk_c2", 1'b1, 32'h0);
        go(); #1; chk_out("sk_c3", 1'b1, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk_out("mid_rst", 1'b0, 32'h0);
        chk("mid_rst_addr", bus.imem_addr, 32'h0);
        chk("mid_rst_fault", {31'd0, fault}, 32'd0);
        chk("mid_rst_fault_pc", fault_pc, 32'h0);
        chk("mid_rst_perf_s", perf_stalls, 32'd0);
        go();
        rst = 1'b0; bus.id_ready = 1'b1; #1;
        chk_out("rs_c0", 1'b0, 32'h0);
        go(); #1; chk("rs_c1_addr", bus.imem_addr, 32'h0);
        go(); #1; chk_out("rs_c2", 1'b1, 32'h0);
        go(); #1; chk_out("rs_c3", 1'b1, 32'h4);

        // Randomized traffic against an in-order delivery model.
        start_after_reset();
        exp_pc = 32'h0; last_pc = 32'h0; prev_stall = 1'b0; hs = 0;
        for (int n = 0; n < 3000; n++) begin
            go();
            fetch_en     = ($urandom_range(0, 19) != 0);
            bus.id_ready = ($urandom_range(0, 9) < 7);
            if (last_pc >= 32'h300 || $urandom_range(0, 29) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'($urandom_range(0, 127)) << 2;
            end else begin
                bus.redirect_valid = 1'b0;
            end
            #1;
            if (bus.redirect_valid) begin
                chk("rnd_redir_bubble", {31'd0, bus.id_valid}, 32'd0);
                if (fetch_en) chk("rnd_redir_addr", bus.imem_addr, bus.redirect_pc);
                exp_pc = bus.redirect_pc;
                last_pc = bus.redirect_pc;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("rnd_hold", {31'd0, bus.id_valid}, 32'd1);
                if (bus.id_valid) begin
                    chk("rnd_pc", bus.id_pc, exp_pc);
                    chk("rnd_instr", bus.id_instr, 32'h0000_1000 + (exp_pc >> 2));
                    last_pc = bus.id_pc;
                    if (bus.id_ready) begin
                        exp_pc = exp_pc + 32'd4;
                        hs++;
                    end
                end
                prev_stall = bus.id_valid & !bus.id_ready;
            end
            chk("rnd_fault", {31'd0, fault}, 32'd0);
        end
        chk("rnd_progress", {31'd0, (hs >= 500)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the synchronous instruction memory.
- Drives the memory byte address and absorbs its one-cycle registered read latency.
- Delivers {pc, instruction} to decode over a valid/ready handshake, with a one-entry skid buffer, branch/jump redirect, and alignment/range fault detection.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- IMEM_BYTES, 1024, instruction memory size in bytes; the last legal word address is IMEM_BYTES-4.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- fetch_en  input  1  level; 1 = fetching permitted.
- imem_addr  output  32  byte address to instruction memory; combinational.
- imem_rdata  input  32  memory read data; valid the cycle after the address was presented.
- redirect_valid  input  1  taken branch/jump from execute, single-cycle pulse.
- redirect_pc  input  32  redirect target byte address.
- id_valid  output  1  instruction available to decode.
- id_ready  input  1  decode accepts this cycle.
- id_pc  output  32  pc of the presented instruction.
- id_instr  output  32  presented instruction.
- fault  output  1  sticky fetch fault.
- fault_pc  output  32  offending address, captured on fault entry.
- perf_fetched  output  32  see Optional Feature.
- perf_stalls  output  32  see Optional Feature.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - state=IDLE, pc_q=RESET_PC; inflight_valid, skid_valid and fault =0.
  - fault_pc, id_pc, id_instr =0; id_valid=0. The in-flight memory response is discarded.
- States:
  - IDLE: no issue; goes to RUN when fetch_en=1.
  - RUN: fetching; goes to IDLE when fetch_en=0, after the in-flight and skid entries drain.
  - FAULT: terminal until rst.
- Issue rule in RUN: issue = fetch_en & (id_ready | (!inflight_valid & !skid_valid)).
  - On issue: imem_addr=pc_q, pc_q<=pc_q+4, inflight_valid<=1, inflight_pc<=pc_q.
  - Without issue: imem_addr=pc_q, inflight_valid<=0.
- Response path (the output mux):
  - id_valid = skid_valid | inflight_valid (forced 0 in IDLE-with-nothing-pending, in FAULT, and in any redirect cycle).
  - id_instr/id_pc come from the skid entry when skid_valid, else from imem_rdata/inflight_pc.
- Skid buffer:
  - Filled when inflight_valid & !id_ready; no issue occurs that cycle, so skid_valid and inflight_valid are never both 1.
  - Cleared when skid_valid & id_ready.
- Latency:
  - First id_valid appears 1 cycle after the first issue.
  - Steady state with id_ready=1: one instruction per cycle.
- Redirect has priority over stall and normal issue.
  - imem_addr=redirect_pc combinationally.
  - pc_q<=redirect_pc+4; inflight_valid<=1; inflight_pc<=redirect_pc; skid_valid<=0; id_valid=0 that cycle.
  - Penalty: 1 bubble.
- Faults (checked on the address about to be issued, including redirect_pc):
  - Trigger when addr[1:0]!=0 or addr>IMEM_BYTES-4.
  - Effect: no issue; state<=FAULT; fault<=1; fault_pc<=addr; inflight/skid entries flushed.
  - In FAULT: imem_addr holds, id_valid=0, redirect_valid ignored.
- Simultaneous events:
  - redirect + id_ready=0: redirect wins and the held instruction is dropped.
  - redirect + fetch_en=0: redirect updates pc_q but no issue; imem_addr=pc_q.
- pc arithmetic is 32-bit modulo; wrap is unreachable because the range check faults first.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - perf_fetched increments on each id_valid&id_ready handshake.
  - perf_stalls increments on each cycle with id_valid&!id_ready.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset, fetch_en=1, id_ready=1, memory word k = 0x1000+k → imem_addr 0,4,8,…; id_pc 0,4,8 with id_instr 0x1000,0x1001,0x1002 on consecutive cycles starting cycle 2.
- id_ready low for 3 cycles while pc 8 is presented → id_pc=8 held stable with id_valid=1; after release, next outputs pc 8, then 12; no loss or duplication; perf_stalls=3 when the macro is defined.
- redirect_valid with redirect_pc=0x40 while stalled on pc 0x10 → pc 0x10 dropped, id_valid=0 that cycle, next output pc 0x40 then 0x44.
- redirect_pc=0x42 → fault=1, fault_pc=0x42, id_valid stays 0, later redirect to 0x0 ignored.
- Sequential fetch reaching 1020, then next pc 1024 → pc 1020 delivered, then fault=1 with fault_pc=0x400.
- rst asserted mid-stall with the skid full → all outputs 0 immediately; after release, fetch restarts at RESET_PC.
